// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: FSM state codes,
// {cpol,cpha} mode codes and the select-width helper.
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // A single-slave build still needs a one-bit select port.
    function automatic int sel_width(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Controller-side handshake and data bus of the SPI master; the local
// controller uses the master modport, the SPI block the slave modport.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
);

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [SEL_W-1:0]  ss_sel;
    logic              cpol;
    logic              cpha;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rx_data;

    modport master (
        output start, tx_data, ss_sel, cpol, cpha,
        input  busy, done, err, rx_data
    );

    modport slave (
        input  start, tx_data, ss_sel, cpol, cpha,
        output busy, done, err, rx_data
    );

endinterface

// File: rtl/spi_clk_gen.sv
// SPI timing generator: one-cycle tick every CLK_DIV system clocks while
// enabled, plus a saturating count of ticks and the leading/trailing flag.
module spi_clk_gen #(
    parameter int CLK_DIV   = 2,
    parameter int NUM_EDGES = 16,
    parameter int CNT_W     = $clog2(NUM_EDGES + 2)
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             en,
    output logic             tick,
    output logic             leading,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] edge_q, edge_d;

    assign tick     = en && (div_q == DIV_W'(CLK_DIV - 1));
    assign leading  = ~edge_q[0];
    assign edge_cnt = edge_q;

    // The tick after the last SPI edge is counted too; it marks the end of HOLD.
    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        if (!en) begin
            div_d  = '0;
            edge_d = '0;
        end else if (tick) begin
            div_d = '0;
            if (edge_q != CNT_W'(NUM_EDGES + 1)) begin
                edge_d = edge_q + CNT_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            edge_q <= '0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with per-transfer CPOL/CPHA, one-hot active-low
// selects and a start/busy/done handshake towards the local controller.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 3,
    parameter int CLK_DIV = 2,
    parameter int SEL_W   = sel_width(NUM_SS)
) (
    input  logic              sclk,
    input  logic              reset,
    spi_master_param_if.slave ctrl,
    output logic              spi_clk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int NUM_EDGES = 2 * DATA_W;
    localparam int CNT_W     = $clog2(NUM_EDGES + 2);
    localparam int BIT_W     = $clog2(DATA_W + 1);

    logic [1:0]        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              spi_clk_q, spi_clk_d;
    logic              mosi_q, mosi_d;
    logic              cpha_q, cpha_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic [BIT_W-1:0]  bit_q, bit_d;

    logic              tick;
    logic              leading;
    logic [CNT_W-1:0]  edge_cnt;
    logic              edge_tick;
    logic              last_edge;
    logic              sample;
    logic              shift_out;
    logic              sel_ok;

    spi_clk_gen #(
        .CLK_DIV   (CLK_DIV),
        .NUM_EDGES (NUM_EDGES),
        .CNT_W     (CNT_W)
    ) u_clk_gen (
        .sclk     (sclk),
        .reset    (reset),
        .en       (state_q != ST_IDLE),
        .tick     (tick),
        .leading  (leading),
        .edge_cnt (edge_cnt)
    );

    assign sel_ok    = 32'(ctrl.ss_sel) < 32'(NUM_SS);
    assign edge_tick = tick && (state_q == ST_SETUP || state_q == ST_XFER);
    assign last_edge = edge_cnt == CNT_W'(NUM_EDGES - 1);

    // cpha=0 samples on leading and shifts on trailing edges; cpha=1 swaps them.
    assign sample    = edge_tick && (leading ^ cpha_q) && (bit_q != BIT_W'(DATA_W));
    assign shift_out = edge_tick && (cpha_q ? leading : (!leading && !last_edge));

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        spi_clk_d = spi_clk_q;
        mosi_d    = mosi_q;
        cpha_d    = cpha_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        ss_n_d    = ss_n_q;
        bit_d     = bit_q;

        case (state_q)
            ST_IDLE: begin
                spi_clk_d = ctrl.cpol;
                if (ctrl.start && sel_ok) begin
                    state_d = ST_SETUP;
                    busy_d  = 1'b1;
                    cpha_d  = ctrl.cpha;
                    ss_n_d  = ~(NUM_SS'(1) << ctrl.ss_sel);
                    rx_sh_d = '0;
                    bit_d   = '0;
                    // In mode cpha=0 the MSB must already be on the line before the first edge.
                    if (ctrl.cpha) begin
                        tx_sh_d = ctrl.tx_data;
                        mosi_d  = 1'b0;
                    end else begin
                        tx_sh_d = ctrl.tx_data << 1;
                        mosi_d  = ctrl.tx_data[DATA_W-1];
                    end
                end else if (ctrl.start) begin
                    err_d = 1'b1;
                end
            end
            ST_SETUP, ST_XFER: begin
                if (tick) begin
                    spi_clk_d = ~spi_clk_q;
                    state_d   = last_edge ? ST_HOLD : ST_XFER;
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d   = ST_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    ss_n_d    = '1;
                    rx_data_d = rx_sh_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (shift_out) begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = tx_sh_q << 1;
        end
        if (sample) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
            bit_d   = bit_q + BIT_W'(1);
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            spi_clk_q <= 1'b0;
            mosi_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            ss_n_q    <= '1;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            spi_clk_q <= spi_clk_d;
            mosi_q    <= mosi_d;
            cpha_q    <= cpha_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            ss_n_q    <= ss_n_d;
            bit_q     <= bit_d;
        end
    end

    assign ctrl.busy    = busy_q;
    assign ctrl.done    = done_q;
    assign ctrl.err     = err_q;
    assign ctrl.rx_data = rx_data_q;
    assign spi_clk      = spi_clk_q;
    assign mosi         = mosi_q;
    assign ss_n         = ss_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Randomised bench for spi_master_param: an edge-driven SPI slave model
// supplies miso and captures mosi; timing follows from the protocol rules.
module tb_spi_master_param;
    import spi_pkg::*;

    localparam int DATA_W   = 8;
    localparam int NUM_SS   = 3;
    localparam int CLK_DIV  = 2;
    localparam int SEL_W    = sel_width(NUM_SS);
    localparam int DONE_CYC = 1 + CLK_DIV * (2 * DATA_W + 1);

    logic              sclk  = 1'b0;
    logic              reset = 1'b0;
    logic              spi_clk;
    logic              mosi;
    logic              miso  = 1'b0;
    logic [NUM_SS-1:0] ss_n;

    spi_master_param_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus();

    spi_master_param #(
        .DATA_W  (DATA_W),
        .NUM_SS  (NUM_SS),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .sclk    (sclk),
        .reset   (reset),
        .ctrl    (bus),
        .spi_clk (spi_clk),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n)
    );

    always #5 sclk = ~sclk;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int clk_edges = 0;

    logic [DATA_W-1:0] slave_word = '0;
    logic [DATA_W-1:0] slv_out    = '0;
    logic [DATA_W-1:0] slv_in     = '0;
    int                slv_lead   = 0;
    int                slv_trail  = 0;
    logic              mode_cpol  = 1'b0;
    logic              mode_cpha  = 1'b0;
    logic              selected   = 1'b0;
    logic              last_clk   = 1'b0;

    always @(posedge sclk) if (bus.done === 1'b1) done_cnt++;
    always @(spi_clk) clk_edges++;

    // SPI slave: leading edge = clock leaving its idle level; it captures on its
    // sample edge and presents the next bit on the opposite edge.
    always @(spi_clk or ss_n) begin
        if (&ss_n) begin
            selected = 1'b0;
        end else if (!selected) begin
            selected  = 1'b1;
            last_clk  = spi_clk;
            slv_out   = slave_word;
            slv_in    = '0;
            slv_lead  = 0;
            slv_trail = 0;
            if (!mode_cpha) begin
                miso    = slv_out[DATA_W-1];
                slv_out = slv_out << 1;
            end
        end else if (spi_clk !== last_clk) begin
            last_clk = spi_clk;
            if (spi_clk != mode_cpol) begin
                slv_lead++;
                if (mode_cpha) begin
                    miso    = slv_out[DATA_W-1];
                    slv_out = slv_out << 1;
                end else begin
                    slv_in = {slv_in[DATA_W-2:0], mosi};
                end
            end else begin
                slv_trail++;
                if (mode_cpha) begin
                    slv_in = {slv_in[DATA_W-2:0], mosi};
                end else begin
                    miso    = slv_out[DATA_W-1];
                    slv_out = slv_out << 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setupInputs(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw,
                               input int sel, input logic [1:0] mode);
        @(negedge sclk);
        {bus.cpol, bus.cpha} = mode;
        {mode_cpol, mode_cpha} = mode;
        bus.tx_data = tx;
        bus.ss_sel  = SEL_W'(sel);
        slave_word  = sw;
        @(negedge sclk);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw,
                                 input int sel, input logic [1:0] mode, input bit perturb);
        int n = 0;
        int ss_bad = 0;
        int busy_bad = 0;
        bit seen = 1'b0;
        int d0;
        logic [NUM_SS-1:0] exp_ss;
        exp_ss = ~(NUM_SS'(1) << sel);
        setupInputs(tx, sw, sel, mode);
        d0 = done_cnt;
        bus.start = 1'b1;
        while (!seen && n < DONE_CYC + 20) begin
            @(negedge sclk);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (perturb) begin
                if (n == 5 || n == 20) bus.start = 1'b1;
                if (n == 6 || n == 21) bus.start = 1'b0;
                if (n == 10) bus.tx_data = ~tx;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (ss_n !== exp_ss) ss_bad++;
                if (bus.busy !== 1'b1) busy_bad++;
            end
        end
        checkOutput("done_seen", 32'(seen), 1);
        checkOutput("done_cycle", n, DONE_CYC);
        checkOutput("ss_n_active", ss_bad, 0);
        checkOutput("busy_active", busy_bad, 0);
        checkOutput("rx_data", 32'(bus.rx_data), 32'(sw));
        checkOutput("mosi_word", 32'(slv_in), 32'(tx));
        checkOutput("lead_edges", slv_lead, DATA_W);
        checkOutput("trail_edges", slv_trail, DATA_W);
        checkOutput("ss_n_done", 32'(ss_n), {NUM_SS{1'b1}});
        checkOutput("busy_done", 32'(bus.busy), 0);
        checkOutput("spi_clk_idle", 32'(spi_clk), 32'(mode[1]));
        @(negedge sclk);
        checkOutput("done_pulse", 32'(bus.done), 0);
        checkOutput("done_count", done_cnt - d0, 1);
    endtask

    task automatic errTest();
        int e0;
        setupInputs(8'h55, 8'h00, NUM_SS, MODE0);
        e0 = clk_edges;
        bus.start = 1'b1;
        @(negedge sclk);
        bus.start = 1'b0;
        checkOutput("err_pulse", 32'(bus.err), 1);
        checkOutput("err_busy", 32'(bus.busy), 0);
        checkOutput("err_ss_n", 32'(ss_n), {NUM_SS{1'b1}});
        @(negedge sclk);
        checkOutput("err_clear", 32'(bus.err), 0);
        repeat (4) @(negedge sclk);
        checkOutput("err_no_edges", clk_edges - e0, 0);
        checkOutput("err_idle_busy", 32'(bus.busy), 0);
    endtask

    task automatic resetTest();
        int d0;
        setupInputs(8'h5A, 8'hC3, 0, MODE2);
        d0 = done_cnt;
        bus.start = 1'b1;
        repeat (12) begin
            @(negedge sclk);
            bus.start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_ss_n", 32'(ss_n), {NUM_SS{1'b1}});
        checkOutput("rst_spi_clk", 32'(spi_clk), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_rx_data", 32'(bus.rx_data), 0);
        repeat (2) @(negedge sclk);
        reset = 1'b0;
        repeat (DONE_CYC + 4) @(negedge sclk);
        checkOutput("rst_no_done", done_cnt - d0, 0);
    endtask

    task automatic backToBackTest();
        int n = 0;
        bit seen = 1'b0;
        int d0;
        setupInputs(8'h96, 8'h4B, 2, MODE1);
        d0 = done_cnt;
        bus.start = 1'b1;
        while (!seen && n < DONE_CYC + 20) begin
            @(negedge sclk);
            n++;
            seen = (bus.done === 1'b1);
        end
        checkOutput("b2b_first_cycle", n, DONE_CYC);
        checkOutput("b2b_first_rx", 32'(bus.rx_data), 32'h4B);
        checkOutput("b2b_first_mosi", 32'(slv_in), 32'h96);
        checkOutput("b2b_gap_high", 32'(ss_n), {NUM_SS{1'b1}});
        bus.tx_data = 8'h3D;
        slave_word  = 8'hE2;
        @(negedge sclk);
        bus.start = 1'b0;
        checkOutput("b2b_gap_low", 32'(ss_n), 32'b011);
        checkOutput("b2b_busy", 32'(bus.busy), 1);
        n = 1;
        seen = 1'b0;
        while (!seen && n < DONE_CYC + 20) begin
            @(negedge sclk);
            n++;
            seen = (bus.done === 1'b1);
        end
        checkOutput("b2b_second_cycle", n, DONE_CYC);
        checkOutput("b2b_second_rx", 32'(bus.rx_data), 32'hE2);
        checkOutput("b2b_second_mosi", 32'(slv_in), 32'h3D);
        @(negedge sclk);
        checkOutput("b2b_done_count", done_cnt - d0, 2);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.tx_data = '0;
        bus.ss_sel  = '0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        #1 reset = 1'b1;
        #2;
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_done", 32'(bus.done), 0);
        checkOutput("reset_err", 32'(bus.err), 0);
        checkOutput("reset_rx", 32'(bus.rx_data), 0);
        checkOutput("reset_spi_clk", 32'(spi_clk), 0);
        checkOutput("reset_mosi", 32'(mosi), 0);
        checkOutput("reset_ss_n", 32'(ss_n), {NUM_SS{1'b1}});
        repeat (3) @(negedge sclk);
        reset = 1'b0;

        $display("[TB] directed modes");
        applyStimulus(8'hA5, 8'h3C, 1, MODE0, 1'b0);
        applyStimulus(8'h81, 8'h7E, 0, MODE1, 1'b0);
        applyStimulus(8'h81, 8'h7E, 2, MODE2, 1'b0);
        applyStimulus(8'h81, 8'h7E, 1, MODE3, 1'b0);

        $display("[TB] invalid select");
        errTest();

        $display("[TB] start and tx_data changes while busy");
        applyStimulus(8'hC6, 8'h19, 2, MODE0, 1'b1);

        $display("[TB] reset mid-transfer");
        resetTest();
        applyStimulus(8'h0F, 8'hF0, 0, MODE3, 1'b0);

        $display("[TB] back-to-back");
        backToBackTest();

        $display("[TB] random transfers");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(DATA_W'($urandom), DATA_W'($urandom), int'($urandom_range(0, NUM_SS - 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised full-duplex SPI master: serial MOSI/MISO, generated SPI clock, one-hot active-low selects for up to NUM_SS slaves.
- Supports all four CPOL/CPHA modes, chosen per transfer.
- Sits between a local controller (start/busy/done handshake, parallel words) and off-chip SPI slaves.
- Replaces the fixed 6-bit, 3-slave, parallel-bus master.

Parameters:
- DATA_W, 8: bits per transfer (2..32), MSB first.
- NUM_SS, 3: number of slave selects (1..8).
- CLK_DIV, 2: sclk cycles per SPI clock half-period (>=1).
- SEL_W, $clog2(NUM_SS) min 1: width of ss_sel.

Ports:
- sclk  in  1  system clock, all logic posedge.
- reset  in  1  asynchronous, active-high.
- start  in  1  transfer request, sampled when busy=0.
- tx_data  in  DATA_W  word to send, latched on accept.
- ss_sel  in  SEL_W  target slave index, latched on accept.
- cpol  in  1  clock idle level, latched on accept.
- cpha  in  1  phase: 0 = sample on leading edge, 1 = sample on trailing edge; latched on accept.
- busy  out  1  high from the cycle after accept through the done cycle (exclusive).
- done  out  1  one-cycle pulse; rx_data valid the same cycle.
- err  out  1  one-cycle pulse when ss_sel >= NUM_SS at start.
- rx_data  out  DATA_W  last received word, held until next done.
- spi_clk  out  1  SPI serial clock.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.
- ss_n  out  NUM_SS  active-low selects, at most one low.

Behaviour:
- Reset (async, immediate, including mid-transfer): busy=0, done=0, err=0, rx_data=0, spi_clk=0, mosi=0, ss_n=all 1, state IDLE, counters 0. Aborted transfers produce no done.
- States: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - spi_clk is registered from the cpol input each cycle.
  - Let start be seen at cycle 0 with busy=0.
  - If ss_sel < NUM_SS: latch tx_data/ss_sel/cpol/cpha, go to SETUP.
  - Otherwise: err=1 at cycle 1, stay IDLE, ss_n untouched.
- SETUP (cycles 1..CLK_DIV):
  - ss_n[sel]=0, busy=1, spi_clk=cpol.
  - If cpha=0, mosi=tx_data[DATA_W-1] from cycle 1; if cpha=1, mosi holds 0.
- XFER:
  - Edges occur at cycles 1+CLK_DIV*k, k=1..2*DATA_W. Odd k are leading edges, even k are trailing edges.
  - cpha=0: sample miso on leading edges; shift the next bit onto mosi on trailing edges, except the last.
  - cpha=1: drive the next bit on leading edges; sample on trailing edges.
  - Receive shift register fills MSB first. Exactly DATA_W samples per transfer.
- HOLD:
  - After edge 2*DATA_W, spi_clk=cpol; ss_n stays low for CLK_DIV cycles.
  - At cycle 1+CLK_DIV*(2*DATA_W+1): ss_n all 1, rx_data updated, done=1, busy=0, return to IDLE. mosi keeps its last value.
- Back-to-back: start asserted in the done cycle is accepted (busy=0). The next SETUP begins the following cycle, so there is a one-cycle ss_n high gap minimum.
- start while busy=1 is ignored. tx_data/ss_sel/cpol/cpha changes during busy have no effect.
- Edge/bit counters saturate at their terminal values. Divider counter wraps at CLK_DIV-1.
- miso is sampled on sclk posedge coincident with the edge tick; no synchroniser inside the block.

Decomposition:
- spi_pkg:
  - state encoding (IDLE/SETUP/XFER/HOLD).
  - mode constants MODE0..MODE3 as {cpol,cpha}.
  - function computing SEL_W.
- Sub-module spi_clk_gen:
  - divider producing a 1-cycle edge tick every CLK_DIV cycles while enabled.
  - leading/trailing flag and edge count.
- The FSM, shift registers and selects stay in spi_master_param.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=2, tx=0xA5, ss_sel=1, slave model returns 0x3C -> ss_n=3'b101 from cycle 1 to cycle 34, mosi bits 1,0,1,0,0,1,0,1, done at cycle 35, rx_data=0x3C.
- Modes 1/2/3 with tx=0x81, slave returns 0x7E -> spi_clk idles at cpol, exactly 8 leading and 8 trailing edges, rx_data=0x7E each mode.
- ss_sel=3 with NUM_SS=3 -> err=1 for one cycle at cycle 1, busy stays 0, ss_n=3'b111, no spi_clk edges.
- start pulsed at cycles 5 and 20 during a transfer, plus tx_data changed mid-transfer -> both ignored, only the original word shifted out, single done.
- reset asserted at cycle 12 of a transfer -> same-cycle ss_n=all 1, spi_clk=0, busy=0, no done. A new start after release completes normally.
- start held high through done -> second transfer accepted in the done cycle; ss_n high for exactly one cycle between transfers; two done pulses with correct rx_data.
